decoder_scan: RTL and testbench



---
 rtl/decoder_scan.sv | 134 +++++++++++++
 tb/tb_decoder_scan.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// -----------------------------------------------------------------------------
// decoder_scan
//
// Registered binary-to-one-hot decoder with enable and an auto-scan mode.
// In direct mode the output follows sel one cycle later. In scan mode the
// one-hot output walks from line 0 to line OUT_W-1 and back to 0. Each line
// is held for dwell+1 cycles, and wrap pulses when the walk returns to line 0.
// Typical uses are LED-matrix rows, keypad scan strobes and bank selects.
//
// Parameters:
//   SEL_W   - width of the binary select
//   DWELL_W - width of the dwell input and the dwell counter
//   OUT_W   - number of one-hot lines, always 2**SEL_W (derived, not settable)
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset, overrides every other input
//   en      - enable; 0 forces y to zero and sends the block to IDLE
//   mode    - 0 = direct decode of sel, 1 = auto-scan
//   sel     - binary select, used in direct mode only
//   dwell   - extra cycles each line is held in scan mode
//   y       - registered one-hot output, or all zeros
//   cur_sel - registered index of the active line (holds its value while y is 0)
//   valid   - registered, equal to |y
//   wrap    - registered one-cycle pulse on the return from line OUT_W-1 to 0
// -----------------------------------------------------------------------------
module decoder_scan #(
   parameter  int SEL_W   = 2,
   parameter  int DWELL_W = 8,
   localparam int OUT_W   = 2 ** SEL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic [DWELL_W-1:0] dwell,
   output logic [OUT_W-1:0]   y,
   output logic [SEL_W-1:0]   cur_sel,
   output logic               valid,
   output logic               wrap
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_e;

   localparam logic [OUT_W-1:0] LINE0 = {{(OUT_W-1){1'b0}}, 1'b1};

   state_e             state_q,   state_d;
   logic [SEL_W-1:0]   idx_q,     idx_d;
   logic [DWELL_W-1:0] cnt_q,     cnt_d;
   logic [OUT_W-1:0]   y_q,       y_d;
   logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
   logic               valid_q,   valid_d;
   logic               wrap_q,    wrap_d;

   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves a value
      // unassigned and no latch can be inferred.
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      y_d       = y_q;
      cur_sel_d = cur_sel_q;
      valid_d   = valid_q;
      wrap_d    = 1'b0;

      if (!en) begin
         // Clearing idx and cnt here makes any later scan start from line 0.
         state_d = ST_IDLE;
         idx_d   = '0;
         cnt_d   = '0;
         y_d     = '0;
         valid_d = 1'b0;
      end else if (!mode) begin
         state_d   = ST_DIRECT;
         idx_d     = '0;
         cnt_d     = '0;
         y_d       = LINE0 << sel;
         cur_sel_d = sel;
         valid_d   = 1'b1;
      end else if (state_q != ST_SCAN) begin
         // Scan entry: line 0 is shown immediately, and dwell is sampled for
         // the first slot.
         state_d   = ST_SCAN;
         idx_d     = '0;
         cnt_d     = dwell;
         y_d       = LINE0;
         cur_sel_d = '0;
         valid_d   = 1'b1;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end else begin
         // Slot end: advance, let idx wrap naturally, and reload dwell.
         idx_d     = idx_q + 1'b1;
         cnt_d     = dwell;
         y_d       = LINE0 << idx_d;
         cur_sel_d = idx_d;
         valid_d   = 1'b1;
         wrap_d    = &idx_q;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments, so every flop
      // samples the values from before the edge.
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         y_q       <= '0;
         cur_sel_q <= '0;
         valid_q   <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         y_q       <= y_d;
         cur_sel_q <= cur_sel_d;
         valid_q   <= valid_d;
         wrap_q    <= wrap_d;
      end
   end

   assign y       = y_q;
   assign cur_sel = cur_sel_q;
   assign valid   = valid_q;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// -----------------------------------------------------------------------------
// tb_decoder_scan
//
// Self-checking bench for decoder_scan with SEL_W=2 and DWELL_W=8. The
// reference model describes the scan as a line number, a slot length and the
// age of the current slot. It is updated at each rising edge using the inputs
// held across that edge.
// -----------------------------------------------------------------------------
module tb_decoder_scan;

   localparam int SEL_W   = 2;
   localparam int DWELL_W = 8;
   localparam int OUT_W   = 2 ** SEL_W;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic               mode;
   logic [SEL_W-1:0]   sel;
   logic [DWELL_W-1:0] dwell;
   logic [OUT_W-1:0]   y;
   logic [SEL_W-1:0]   cur_sel;
   logic               valid;
   logic               wrap;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state.
   logic [OUT_W-1:0] m_y;
   logic [SEL_W-1:0] m_cur;
   logic             m_valid;
   logic             m_wrap;
   bit               m_scanning;
   int               m_line;
   int               m_slot_len;
   int               m_age;

   decoder_scan #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode),
      .sel     (sel),
      .dwell   (dwell),
      .y       (y),
      .cur_sel (cur_sel),
      .valid   (valid),
      .wrap    (wrap)
   );

   always #5 clk = ~clk;

   // One edge of the reference behaviour, using the inputs seen at that edge.
   task automatic model_step();
      logic [OUT_W-1:0] one;
      one    = 1;
      m_wrap = 1'b0;
      if (rst) begin
         m_y = '0; m_cur = '0; m_valid = 1'b0; m_scanning = 0;
      end else if (!en) begin
         m_y = '0; m_valid = 1'b0; m_scanning = 0;
      end else if (!mode) begin
         m_y = one << sel; m_cur = sel; m_valid = 1'b1; m_scanning = 0;
      end else if (!m_scanning) begin
         m_scanning = 1;
         m_line     = 0;
         m_slot_len = int'(dwell) + 1;
         m_age      = 1;
         m_y = one; m_cur = '0; m_valid = 1'b1;
      end else if (m_age < m_slot_len) begin
         m_age++;
      end else begin
         m_wrap     = (m_line == OUT_W - 1);
         m_line     = (m_line + 1) % OUT_W;
         m_slot_len = int'(dwell) + 1;
         m_age      = 1;
         m_y = one << m_line; m_cur = SEL_W'(m_line); m_valid = 1'b1;
      end
   endtask

   // Advance one edge, update the model, and leave time so outputs settle.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic go_idle();
      rst = 1'b0; en = 1'b0; mode = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; mode = 1'b1; sel = '0; dwell = '0;
      tick(); tick();
      n_tests++;
      if ({y, valid, wrap, cur_sel} !== {4'b0000, 1'b0, 1'b0, 2'b00}) begin
         n_fail++;
         $display("FAIL reset_state: y=%b valid=%b wrap=%b cur_sel=%b, want 0000 0 0 00",
                  y, valid, wrap, cur_sel);
      end
      rst = 1'b0;
      tick();
      n_tests++;
      if (y !== 4'b0001 || valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: y=%b valid=%b, want 0001 1", y, valid);
      end
   endtask

   task automatic test_direct();
      logic [OUT_W-1:0] want;
      rst = 1'b0; en = 1'b1; mode = 1'b0;
      for (int i = 0; i < OUT_W; i++) begin
         sel = SEL_W'(i);
         tick();
         want = '0;
         want[i] = 1'b1;
         n_tests++;
         if (y !== want || valid !== 1'b1 || cur_sel !== SEL_W'(i) || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_sel%0d: y=%b cur_sel=%0d valid=%b wrap=%b, want %b %0d 1 0",
                     i, y, cur_sel, valid, wrap, want, i);
         end
      end
      en = 1'b0; sel = 2'b10;
      tick();
      n_tests++;
      if (y !== 4'b0000 || valid !== 1'b0) begin
         n_fail++;
         $display("FAIL direct_disable: y=%b valid=%b, want 0000 0", y, valid);
      end
   endtask

   task automatic test_scan_dwell0();
      logic [OUT_W-1:0] exp_y [5];
      logic [SEL_W-1:0] exp_c [5];
      logic             exp_w [5];
      exp_y = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      go_idle();
      en = 1'b1; mode = 1'b1; dwell = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if (y !== exp_y[i] || cur_sel !== exp_c[i] || wrap !== exp_w[i] || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_d0_step%0d: y=%b cur_sel=%0d wrap=%b, want %b %0d %b",
                     i, y, cur_sel, wrap, exp_y[i], exp_c[i], exp_w[i]);
         end
      end
   endtask

   task automatic test_scan_dwell2();
      int               wraps;
      int               run;
      int               bad_runs;
      logic [OUT_W-1:0] prev;
      go_idle();
      en = 1'b1; mode = 1'b1; dwell = 8'd2;
      tick();
      wraps = 0; run = 1; bad_runs = 0; prev = y;
      // Line 0 entry plus 24 more edges gives two full 12-cycle periods.
      for (int i = 0; i < 24; i++) begin
         tick();
         if (wrap === 1'b1) wraps++;
         if (y === prev) run++;
         else begin
            if (run != 3) bad_runs++;
            run = 1;
         end
         prev = y;
      end
      n_tests++;
      if (wraps != 2 || bad_runs != 0) begin
         n_fail++;
         $display("FAIL scan_d2_period: wraps=%0d bad_slots=%0d, want 2 0", wraps, bad_runs);
      end
      // Change dwell mid-slot. The current slot keeps 3 cycles and later
      // slots take 1 cycle.
      go_idle();
      en = 1'b1; mode = 1'b1; dwell = 8'd2;
      tick();
      dwell = 8'd0;
      tick(); tick();
      n_tests++;
      if (y !== 4'b0001) begin
         n_fail++;
         $display("FAIL dwell_change_hold: y=%b, want 0001", y);
      end
      tick();
      n_tests++;
      if (y !== 4'b0010) begin
         n_fail++;
         $display("FAIL dwell_change_adv1: y=%b, want 0010", y);
      end
      tick();
      n_tests++;
      if (y !== 4'b0100) begin
         n_fail++;
         $display("FAIL dwell_change_adv2: y=%b, want 0100", y);
      end
   endtask

   task automatic test_interrupt();
      go_idle();
      en = 1'b1; mode = 1'b1; dwell = '0;
      tick(); tick(); tick();
      n_tests++;
      if (y !== 4'b0100) begin
         n_fail++;
         $display("FAIL intr_setup: y=%b, want 0100", y);
      end
      rst = 1'b1;
      tick();
      n_tests++;
      if (y !== 4'b0000 || valid !== 1'b0) begin
         n_fail++;
         $display("FAIL intr_reset: y=%b valid=%b, want 0000 0", y, valid);
      end
      rst = 1'b0;
      tick();
      n_tests++;
      if (y !== 4'b0001 || cur_sel !== 2'd0) begin
         n_fail++;
         $display("FAIL intr_reset_restart: y=%b cur_sel=%0d, want 0001 0", y, cur_sel);
      end
      tick();
      en = 1'b0;
      tick();
      n_tests++;
      if (y !== 4'b0000 || valid !== 1'b0 || cur_sel !== 2'd1) begin
         n_fail++;
         $display("FAIL intr_en_drop: y=%b valid=%b cur_sel=%0d, want 0000 0 1", y, valid, cur_sel);
      end
      en = 1'b1;
      tick();
      n_tests++;
      if (y !== 4'b0001 || wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL intr_en_restart: y=%b wrap=%b, want 0001 0", y, wrap);
      end
   endtask

   task automatic test_mode_switch();
      go_idle();
      en = 1'b1; mode = 1'b1; dwell = '0;
      tick(); tick();
      mode = 1'b0; sel = 2'b11;
      tick();
      n_tests++;
      if (y !== 4'b1000 || cur_sel !== 2'b11) begin
         n_fail++;
         $display("FAIL mode_to_direct: y=%b cur_sel=%b, want 1000 11", y, cur_sel);
      end
      mode = 1'b1;
      tick();
      n_tests++;
      if (y !== 4'b0001 || cur_sel !== 2'b00) begin
         n_fail++;
         $display("FAIL mode_to_scan: y=%b cur_sel=%b, want 0001 00", y, cur_sel);
      end
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 99) == 0);
         en    = ($urandom_range(0, 24) != 0);
         mode  = ($urandom_range(0, 29) != 0);
         sel   = SEL_W'($urandom);
         dwell = ($urandom_range(0, 9) == 0) ? DWELL_W'($urandom_range(0, 12))
                                             : DWELL_W'($urandom_range(0, 3));
         tick();
         n_tests++;
         if ({y, cur_sel, valid, wrap} !== {m_y, m_cur, m_valid, m_wrap}
             || !$onehot0(y) || valid !== (|y)) begin
            n_fail++;
            if (errs < 10)
               $display("FAIL random_cycle%0d: y=%b cur_sel=%0d valid=%b wrap=%b, want %b %0d %b %b",
                        i, y, cur_sel, valid, wrap, m_y, m_cur, m_valid, m_wrap);
            errs++;
         end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; dwell = '0;
      m_y = '0; m_cur = '0; m_valid = 1'b0; m_wrap = 1'b0;
      m_scanning = 0; m_line = 0; m_slot_len = 1; m_age = 1;
      test_reset();
      test_direct();
      test_scan_dwell0();
      test_scan_dwell2();
      test_interrupt();
      test_mode_switch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
